// File: rtl/frame_loader.sv
// -----------------------------------------------------------------------------
// frame_loader
//
// Receives a byte stream from a UART receiver and loads complete image frames
// into a two-bank (ping-pong) RAM through a simple write port. A frame is an
// optional start marker pair, IMG_SIZE payload bytes and an end marker pair.
// Finished frames mark their bank full until the consumer releases it. The
// loader stops loading while the bank it would write next is still full.
// A malformed trailer, an idle gap inside a frame or a byte that arrives while
// the target bank is full raises a one-cycle error pulse with a cause code.
//
// Ports
//   clk              in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   enable_i         in   loader active; low freezes frame progress and
//                         ignores incoming bytes
//   rx_data_i        in   8-bit UART byte
//   rx_ready_i       in   one-cycle strobe, rx_data_i valid
//   release_i        in   one-cycle strobe, consumer done with a bank
//   release_bank_i   in   bank being released
//   wr_en_o          out  RAM write enable
//   wr_bank_o        out  bank currently being filled (RAM address MSB)
//   wr_addr_o        out  RAM word address within the bank
//   wr_data_o        out  RAM write data
//   image_loaded_o   out  one-cycle pulse, frame complete
//   loaded_bank_o    out  bank of the most recently completed frame
//   bank_full_o      out  per-bank "holds an unconsumed frame"
//   frame_err_o      out  one-cycle pulse on any frame error
//   err_code_o       out  cause of last error: 1 bad end, 2 timeout, 3 overrun
//   rx_count_o       out  saturating count of bytes accepted while enabled
// -----------------------------------------------------------------------------
module frame_loader #(
    parameter int         IMG_SIZE = 784,
    parameter int         ADDR_W   = 10,
    parameter bit         START_EN = 1'b1,
    parameter logic [7:0] START1   = 8'hAA,
    parameter logic [7:0] START2   = 8'h55,
    parameter logic [7:0] END1     = 8'h66,
    parameter logic [7:0] END2     = 8'hBB,
    parameter int         TIMEOUT  = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_ready_i,
    input  logic              release_i,
    input  logic              release_bank_i,
    output logic              wr_en_o,
    output logic              wr_bank_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              image_loaded_o,
    output logic              loaded_bank_o,
    output logic [1:0]        bank_full_o,
    output logic              frame_err_o,
    output logic [1:0]        err_code_o,
    output logic [15:0]       rx_count_o
);

    // Idle counter only has to reach TIMEOUT; a 1-bit stub when disabled.
    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_SIZE - 1);

    localparam logic [1:0] ERR_BAD_END = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_PAYLOAD,
        ST_TRAIL1,
        ST_TRAIL2
    } state_t;

    state_t              state_q, state_d;

    // Input stage
    logic [7:0]          rx_data_q;
    logic                rx_ready_q;

    // Frame progress
    logic [ADDR_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic                prev_s1_q, prev_s1_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [IDLE_W-1:0]   idle_inc;

    // Bank bookkeeping
    logic                wr_bank_q, wr_bank_d;
    logic                loaded_bank_q, loaded_bank_d;
    logic [1:0]          bank_full_q, bank_full_d;
    logic [1:0]          bank_set;

    // Registered outputs
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                image_loaded_q, image_loaded_d;
    logic                frame_err_q, frame_err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [15:0]         rx_count_q, rx_count_d;

    // Error request from the frame logic, applied once after the case.
    logic                err_hit;
    logic [1:0]          err_kind;
    logic                byte_acc;

    // A byte is only acted upon when it has passed the input stage and the
    // loader is enabled; bytes arriving while disabled are simply dropped.
    assign byte_acc = rx_ready_q & enable_i;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q      <= '0;
            rx_ready_q     <= 1'b0;
            byte_cnt_q     <= '0;
            prev_s1_q      <= 1'b0;
            idle_q         <= '0;
            wr_bank_q      <= 1'b0;
            loaded_bank_q  <= 1'b0;
            bank_full_q    <= 2'b00;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            image_loaded_q <= 1'b0;
            frame_err_q    <= 1'b0;
            err_code_q     <= 2'd0;
            rx_count_q     <= '0;
        end else begin
            rx_data_q      <= rx_data_i;
            rx_ready_q     <= rx_ready_i;
            byte_cnt_q     <= byte_cnt_d;
            prev_s1_q      <= prev_s1_d;
            idle_q         <= idle_d;
            wr_bank_q      <= wr_bank_d;
            loaded_bank_q  <= loaded_bank_d;
            bank_full_q    <= bank_full_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            image_loaded_q <= image_loaded_d;
            frame_err_q    <= frame_err_d;
            err_code_q     <= err_code_d;
            rx_count_q     <= rx_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        prev_s1_d      = prev_s1_q;
        idle_d         = idle_q;
        idle_inc       = idle_q + 1'b1;
        wr_bank_d      = wr_bank_q;
        loaded_bank_d  = loaded_bank_q;
        bank_set       = 2'b00;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        image_loaded_d = 1'b0;
        frame_err_d    = 1'b0;
        err_code_d     = err_code_q;
        rx_count_d     = rx_count_q;
        err_hit        = 1'b0;
        err_kind       = ERR_BAD_END;

        if (byte_acc) begin
            if (rx_count_q != 16'hFFFF) begin
                rx_count_d = rx_count_q + 16'd1;
            end
            idle_d = '0;

            unique case (state_q)
                ST_SYNC: begin
                    if (bank_full_q[wr_bank_q]) begin
                        // Consumer has not freed the target bank yet.
                        err_hit  = 1'b1;
                        err_kind = ERR_OVERRUN;
                    end else if (START_EN) begin
                        // A repeated START1 keeps the hunt armed, so
                        // START1 START1 START2 still opens a frame.
                        if (prev_s1_q && (rx_data_q == START2)) begin
                            state_d    = ST_PAYLOAD;
                            byte_cnt_d = '0;
                            prev_s1_d  = 1'b0;
                        end else begin
                            prev_s1_d = (rx_data_q == START1);
                        end
                    end else begin
                        // Without markers the first byte is payload byte 0.
                        wr_en_d    = 1'b1;
                        wr_addr_d  = '0;
                        wr_data_d  = rx_data_q;
                        byte_cnt_d = ADDR_W'(1);
                        state_d    = ST_PAYLOAD;
                    end
                end

                ST_PAYLOAD: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = byte_cnt_q;
                    wr_data_d = rx_data_q;
                    if (byte_cnt_q == LAST_ADDR) begin
                        byte_cnt_d = '0;
                        state_d    = ST_TRAIL1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end

                ST_TRAIL1: begin
                    if (rx_data_q == END1) begin
                        state_d = ST_TRAIL2;
                    end else begin
                        err_hit = 1'b1;
                    end
                end

                ST_TRAIL2: begin
                    if (rx_data_q == END2) begin
                        image_loaded_d      = 1'b1;
                        loaded_bank_d       = wr_bank_q;
                        bank_set[wr_bank_q] = 1'b1;
                        wr_bank_d           = ~wr_bank_q;
                        state_d             = ST_SYNC;
                    end else begin
                        err_hit = 1'b1;
                    end
                end

                default: state_d = ST_SYNC;
            endcase
        end else if (enable_i && (state_q != ST_SYNC) && (TIMEOUT != 0)) begin
            // Idle cycle inside a frame.
            if (idle_inc == IDLE_LIMIT) begin
                err_hit  = 1'b1;
                err_kind = ERR_TIMEOUT;
            end else begin
                idle_d = idle_inc;
            end
        end

        // Every error abandons the partial frame; the same bank is refilled.
        if (err_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = err_kind;
            state_d     = ST_SYNC;
            byte_cnt_d  = '0;
            prev_s1_d   = 1'b0;
            idle_d      = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Bank full flags: a completion setting a bank overrides a release of the
    // same bank in the same cycle.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        assign bank_full_d[gi] = bank_set[gi] |
                                 (bank_full_q[gi] &
                                  ~(release_i & (release_bank_i == 1'(gi))));
    end

    assign wr_en_o        = wr_en_q;
    assign wr_bank_o      = wr_bank_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign image_loaded_o = image_loaded_q;
    assign loaded_bank_o  = loaded_bank_q;
    assign bank_full_o    = bank_full_q;
    assign frame_err_o    = frame_err_q;
    assign err_code_o     = err_code_q;
    assign rx_count_o     = rx_count_q;

endmodule

// File: tb/tb_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_frame_loader
//
// Two loaders share clock, reset, enable and release: instance A uses start
// markers with full-size frames and a short timeout, instance B runs without
// markers on 4-byte frames. A frame-level model of each loader runs on every
// clock edge and all registered outputs are compared once per cycle on the
// falling edge. Directed phases pin the model with hand-computed numbers.
// -----------------------------------------------------------------------------
module tb_frame_loader;

    localparam int A_IMG = 784;
    localparam int A_TO  = 100;
    localparam int B_IMG = 4;
    localparam int B_TO  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] rx_data_a = 8'h00;
    logic       rx_ready_a = 1'b0;
    logic [7:0] rx_data_b = 8'h00;
    logic       rx_ready_b = 1'b0;
    logic       release_s = 1'b0;
    logic       release_bank_s = 1'b0;

    logic       a_wr_en, a_wr_bank, a_image_loaded, a_loaded_bank, a_frame_err;
    logic [9:0] a_wr_addr;
    logic [7:0] a_wr_data;
    logic [1:0] a_bank_full, a_err_code;
    logic [15:0] a_rx_count;
    logic       b_wr_en, b_wr_bank, b_image_loaded, b_loaded_bank, b_frame_err;
    logic [1:0] b_wr_addr;
    logic [7:0] b_wr_data;
    logic [1:0] b_bank_full, b_err_code;
    logic [15:0] b_rx_count;

    always #5 clk = ~clk;

    frame_loader #(.IMG_SIZE(A_IMG), .ADDR_W(10), .START_EN(1'b1), .TIMEOUT(A_TO)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable_i(enable),
        .rx_data_i(rx_data_a), .rx_ready_i(rx_ready_a),
        .release_i(release_s), .release_bank_i(release_bank_s),
        .wr_en_o(a_wr_en), .wr_bank_o(a_wr_bank), .wr_addr_o(a_wr_addr), .wr_data_o(a_wr_data),
        .image_loaded_o(a_image_loaded), .loaded_bank_o(a_loaded_bank), .bank_full_o(a_bank_full),
        .frame_err_o(a_frame_err), .err_code_o(a_err_code), .rx_count_o(a_rx_count));

    frame_loader #(.IMG_SIZE(B_IMG), .ADDR_W(2), .START_EN(1'b0), .TIMEOUT(B_TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable_i(enable),
        .rx_data_i(rx_data_b), .rx_ready_i(rx_ready_b),
        .release_i(release_s), .release_bank_i(release_bank_s),
        .wr_en_o(b_wr_en), .wr_bank_o(b_wr_bank), .wr_addr_o(b_wr_addr), .wr_data_o(b_wr_data),
        .image_loaded_o(b_image_loaded), .loaded_bank_o(b_loaded_bank), .bank_full_o(b_bank_full),
        .frame_err_o(b_frame_err), .err_code_o(b_err_code), .rx_count_o(b_rx_count));

    // ------------------------------------------------------------------
    // Frame-level model. pos counts bytes into the frame body: 0..img-1
    // payload, img = expecting first end byte, img+1 = expecting second.
    // ------------------------------------------------------------------
    typedef struct {
        bit        in_frame;
        int        pos;
        bit        prev_s1;
        int        idle;
        bit [1:0]  full;
        bit        bank;
        bit        lbank;
        bit [1:0]  code;
        int        cnt;
        bit        pv;
        bit [7:0]  pd;
        bit        we;
        int        waddr;
        bit [7:0]  wdata;
        bit        il;
        bit        fe;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.in_frame = 0; s.pos = 0; s.prev_s1 = 0; s.idle = 0; s.full = 2'b00;
        s.bank = 0; s.lbank = 0; s.code = 0; s.cnt = 0; s.pv = 0; s.pd = 0;
        s.we = 0; s.waddr = 0; s.wdata = 0; s.il = 0; s.fe = 0;
        return s;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, bit en, bit rv, bit [7:0] rd,
                                      bit rel, bit relb, int img, bit sen, int to);
        mdl_t     n = s;
        bit       do_set = 0;
        bit       err = 0;
        bit [1:0] code = 0;
        n.il = 0; n.fe = 0; n.we = 0;
        if (s.pv && en) begin
            if (n.cnt < 65535) n.cnt = n.cnt + 1;
            n.idle = 0;
            if (!s.in_frame) begin
                if (s.full[s.bank]) begin
                    err = 1; code = 3;
                end else if (sen) begin
                    if (s.prev_s1 && s.pd == 8'h55) begin
                        n.in_frame = 1; n.pos = 0; n.prev_s1 = 0;
                    end else begin
                        n.prev_s1 = (s.pd == 8'hAA);
                    end
                end else begin
                    n.we = 1; n.waddr = 0; n.wdata = s.pd; n.in_frame = 1; n.pos = 1;
                end
            end else if (s.pos < img) begin
                n.we = 1; n.waddr = s.pos; n.wdata = s.pd; n.pos = s.pos + 1;
            end else if (s.pos == img) begin
                if (s.pd == 8'h66) n.pos = img + 1;
                else begin err = 1; code = 1; end
            end else begin
                if (s.pd == 8'hBB) begin
                    n.il = 1; n.lbank = s.bank; do_set = 1;
                    n.bank = ~s.bank; n.in_frame = 0; n.pos = 0;
                end else begin
                    err = 1; code = 1;
                end
            end
        end else if (en && s.in_frame && to != 0) begin
            n.idle = s.idle + 1;
            if (n.idle == to) begin err = 1; code = 2; end
        end
        if (err) begin
            n.fe = 1; n.code = code; n.in_frame = 0; n.pos = 0; n.prev_s1 = 0; n.idle = 0;
        end
        if (rel) n.full[relb] = 0;
        if (do_set) n.full[s.bank] = 1;
        n.pv = rv; n.pd = rd;
        return n;
    endfunction

    mdl_t ma, mb;

    initial begin
        ma = mdl_reset();
        mb = mdl_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ma = mdl_reset();
                mb = mdl_reset();
            end else begin
                ma = mdl_step(ma, enable, rx_ready_a, rx_data_a, release_s, release_bank_s, A_IMG, 1'b1, A_TO);
                mb = mdl_step(mb, enable, rx_ready_b, rx_data_b, release_s, release_bank_s, B_IMG, 1'b0, B_TO);
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking and stimulus (single process)
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int a_writes = 0, a_loads = 0, a_errs = 0, a_bad_data = 0;
    int a_last_wr = 0, a_err_cyc = 0;
    int b_loads = 0;
    int b_log[$];
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit rand_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [42:0] pk(logic we, logic wb, logic [9:0] wa, logic [7:0] wd,
                                       logic il, logic lb, logic [1:0] bf, logic fe,
                                       logic [1:0] ec, logic [15:0] cnt);
        return {we, wb, (we ? wa : 10'd0), (we ? wd : 8'd0), il, lb, bf, fe, ec, cnt};
    endfunction

    task automatic compare_all();
        cyc++;
        chk("dut_a_outputs",
            {21'd0, pk(a_wr_en, a_wr_bank, a_wr_addr, a_wr_data, a_image_loaded, a_loaded_bank,
                       a_bank_full, a_frame_err, a_err_code, a_rx_count)},
            {21'd0, pk(ma.we, ma.bank, 10'(ma.waddr), ma.wdata, ma.il, ma.lbank,
                       ma.full, ma.fe, ma.code, 16'(ma.cnt))});
        chk("dut_b_outputs",
            {21'd0, pk(b_wr_en, b_wr_bank, {8'd0, b_wr_addr}, b_wr_data, b_image_loaded, b_loaded_bank,
                       b_bank_full, b_frame_err, b_err_code, b_rx_count)},
            {21'd0, pk(mb.we, mb.bank, 10'(mb.waddr), mb.wdata, mb.il, mb.lbank,
                       mb.full, mb.fe, mb.code, 16'(mb.cnt))});
        if (a_wr_en === 1'b1) begin
            a_writes++;
            a_last_wr = cyc;
            if (a_wr_data !== a_wr_addr[7:0]) a_bad_data++;
        end
        if (a_image_loaded === 1'b1) a_loads++;
        if (a_frame_err === 1'b1) begin a_errs++; a_err_cyc = cyc; end
        if (b_image_loaded === 1'b1) b_loads++;
        if (b_wr_en === 1'b1) b_log.push_back((int'(b_wr_bank) << 10) | (int'(b_wr_addr) << 8) | int'(b_wr_data));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked
    // on the falling edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int extra, input int gap_max);
        int idle_n = 0;
        while (qa.size() != 0 || qb.size() != 0 || idle_n < extra) begin
            rx_ready_a = 0;
            rx_ready_b = 0;
            if (qa.size() != 0 && $urandom_range(0, gap_max) == 0) begin
                rx_data_a = qa.pop_front(); rx_ready_a = 1;
            end
            if (qb.size() != 0 && $urandom_range(0, gap_max) == 0) begin
                rx_data_b = qb.pop_front(); rx_ready_b = 1;
            end
            if (rand_mode) begin
                enable         = ($urandom_range(0, 15) != 0);
                release_s      = ($urandom_range(0, 39) == 0);
                release_bank_s = 1'($urandom_range(0, 1));
            end else begin
                enable    = 1;
                release_s = 0;
            end
            if (qa.size() == 0 && qb.size() == 0) idle_n++;
            tick();
        end
        rx_ready_a = 0; rx_ready_b = 0; release_s = 0; enable = 1;
    endtask

    task automatic pulse_release(input bit bank);
        release_s = 1; release_bank_s = bank;
        tick();
        release_s = 0;
    endtask

    function automatic logic [7:0] junk_byte();
        case ($urandom_range(0, 4))
            0: return 8'hAA;
            1: return 8'h55;
            2: return 8'h66;
            3: return 8'hBB;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // kind: 0 good, 1 bad second end byte, 2 bad first end byte,
    //       3 truncated payload, 4 junk; ramp = payload equals address
    task automatic push_a(input int kind, input bit ramp);
        if (kind == 4) begin
            for (int i = 0; i < 20; i++) qa.push_back(junk_byte());
            return;
        end
        qa.push_back(8'hAA); qa.push_back(8'h55);
        for (int i = 0; i < ((kind == 3) ? 100 : A_IMG); i++)
            qa.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
        if (kind == 0) begin qa.push_back(8'h66); qa.push_back(8'hBB); end
        if (kind == 1) begin qa.push_back(8'h66); qa.push_back(8'hBC); end
        if (kind == 2) begin qa.push_back(8'h00); qa.push_back(8'hBB); end
    endtask

    task automatic push_b(input int kind);
        int n = (kind == 3) ? 2 : B_IMG;
        if (kind == 4) begin
            for (int i = 0; i < 5; i++) qb.push_back(junk_byte());
            return;
        end
        for (int i = 0; i < n; i++) qb.push_back(8'($urandom_range(0, 255)));
        if (kind == 0) begin qb.push_back(8'h66); qb.push_back(8'hBB); end
        if (kind == 1) begin qb.push_back(8'h66); qb.push_back(8'h00); end
        if (kind == 2) begin qb.push_back(8'h67); qb.push_back(8'hBB); end
    endtask

    int s_wr, s_ld, s_er, s_bd, s_bl, s_blog;

    initial begin
        repeat (3) tick();
        chk("reset_a_state", {a_wr_en, a_image_loaded, a_frame_err, a_err_code, a_bank_full, a_rx_count}, 0);
        rst_n = 1;
        tick();

        // Known-value frames on both loaders.
        s_wr = a_writes; s_ld = a_loads; s_bd = a_bad_data; s_bl = b_loads; s_blog = b_log.size();
        push_a(0, 1'b1);
        qb.push_back(8'h01); qb.push_back(8'h02); qb.push_back(8'h03); qb.push_back(8'h04);
        qb.push_back(8'h66); qb.push_back(8'hBB);
        drain(6, 1);
        chk("a_frame1_writes", a_writes - s_wr, 784);
        chk("a_frame1_loads", a_loads - s_ld, 1);
        chk("a_frame1_data", a_bad_data - s_bd, 0);
        chk("a_frame1_bank", {a_loaded_bank, a_bank_full}, {1'b0, 2'b01});
        chk("b_frame1_loads", b_loads - s_bl, 1);
        chk("b_frame1_nwrites", b_log.size() - s_blog, 4);
        for (int i = 0; i < 4; i++)
            if (s_blog + i < b_log.size())
                chk("b_frame1_write", b_log[s_blog + i], (i << 8) | (i + 1));
        chk("b_frame1_bank", b_bank_full, 2'b01);

        // Fill both banks, then overrun.
        push_a(0, 1'b0);
        drain(6, 1);
        chk("a_both_full", {a_loaded_bank, a_bank_full}, {1'b1, 2'b11});
        s_wr = a_writes; s_er = a_errs;
        push_a(0, 1'b0);
        drain(6, 0);
        chk("a_overrun_errs", a_errs - s_er, 788);
        chk("a_overrun_writes", a_writes - s_wr, 0);
        chk("a_overrun_code", a_err_code, 3);
        pulse_release(1'b0);
        s_ld = a_loads;
        push_a(0, 1'b0);
        drain(6, 1);
        chk("a_resend_loads", a_loads - s_ld, 1);
        chk("a_resend_bank", {a_loaded_bank, a_bank_full}, {1'b0, 2'b11});

        // Bad trailer, then a good frame into the same bank.
        pulse_release(1'b0);
        pulse_release(1'b1);
        s_ld = a_loads;
        push_a(1, 1'b0);
        drain(6, 1);
        chk("a_badend_code", a_err_code, 1);
        chk("a_badend_loads", a_loads - s_ld, 0);
        chk("a_badend_full", a_bank_full, 2'b00);
        push_a(0, 1'b0);
        drain(6, 1);
        chk("a_after_bad_bank", {a_loaded_bank, a_bank_full}, {1'b1, 2'b10});

        // Stall mid-payload until the timeout fires.
        pulse_release(1'b1);
        s_er = a_errs;
        qa.push_back(8'hAA); qa.push_back(8'h55);
        for (int i = 0; i < 300; i++) qa.push_back(8'($urandom_range(0, 255)));
        drain(150, 1);
        chk("a_timeout_errs", a_errs - s_er, 1);
        chk("a_timeout_gap", a_err_cyc - a_last_wr, A_TO);
        chk("a_timeout_code", a_err_code, 2);

        // Randomised traffic with enable drops and releases.
        rand_mode = 1;
        for (int k = 0; k < 6; k++) begin
            push_a($urandom_range(0, 4), 1'b0);
            for (int j = 0; j < 8; j++) push_b($urandom_range(0, 4));
            drain(40, 1);
        end
        push_b(3);
        drain(60, 0);
        rand_mode = 0;
        drain(4, 0);

        // Reset in the middle of a frame.
        pulse_release(1'b0);
        pulse_release(1'b1);
        qa.push_back(8'hAA); qa.push_back(8'h55);
        for (int i = 0; i < 10; i++) qa.push_back(8'(i));
        qb.push_back(8'h01); qb.push_back(8'h02);
        drain(3, 0);
        rst_n = 0;
        tick();
        tick();
        chk("rst_a_outputs", {a_wr_en, a_wr_bank, a_wr_addr, a_wr_data, a_image_loaded, a_loaded_bank,
                              a_bank_full, a_frame_err, a_err_code, a_rx_count}, 0);
        chk("rst_b_outputs", {b_wr_en, b_wr_bank, b_wr_addr, b_wr_data, b_image_loaded, b_loaded_bank,
                              b_bank_full, b_frame_err, b_err_code, b_rx_count}, 0);
        rst_n = 1;
        tick();
        rx_data_b = 8'h05; rx_ready_b = 1;
        tick();
        rx_ready_b = 0;
        chk("b_latency_1cycle", b_wr_en, 0);
        tick();
        chk("b_latency_2cycle", {b_wr_en, b_wr_bank, b_wr_addr, b_wr_data}, {1'b1, 1'b0, 2'd0, 8'h05});
        s_bl = b_loads;
        qb.push_back(8'h06); qb.push_back(8'h07); qb.push_back(8'h08);
        qb.push_back(8'h66); qb.push_back(8'hBB);
        drain(6, 1);
        chk("b_post_reset_load", {b_loaded_bank, b_bank_full, 8'(b_loads - s_bl)}, {1'b0, 2'b01, 8'd1});
        chk("b_post_reset_count", b_rx_count, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
